// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request side driven by the stage (master),
// response side driven by the memory (slave).
interface mem_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            DMemReq;
    logic            DMemWe;
    logic [XLEN-1:0] DMemAddr;
    logic [XLEN-1:0] DMemWData;
    logic [3:0]      DMemBe;
    logic [XLEN-1:0] DMemRData;
    logic            DMemReady;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
        input  DMemRData, DMemReady
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemBe,
        output DMemRData, DMemReady
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: EX/MEM pipeline register, data-memory request with
// ready handshake and stall, store lane steering and load extension.
// Optional feature: define MEM_STAGE_MISALIGN_CHECK_EN to detect misaligned
// half/word accesses (request suppressed, MisalignM raised, load write masked).
module mem_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic            FlushE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            MisalignM,
    mem_stage_if.master     dmem
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] alu_q, wdata_q, pc4_q;
    logic [4:0]      rd_q;
    logic            regwrite_q, memwrite_q;
    logic [1:0]      rsrc_q;
    logic [2:0]      funct3_q;

    logic            load, mem_op, misalign, req;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    // EX/MEM register: holds while stalled, takes a bubble on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q      <= '0;
            wdata_q    <= '0;
            pc4_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            rsrc_q     <= 2'b00;
            funct3_q   <= 3'b000;
        end else if (!StallM) begin
            alu_q    <= ALUResultE;
            wdata_q  <= WriteDataE;
            pc4_q    <= PCPlus4E;
            rd_q     <= RdE;
            funct3_q <= Funct3E;
            if (FlushE) begin
                regwrite_q <= 1'b0;
                memwrite_q <= 1'b0;
                rsrc_q     <= 2'b00;
            end else begin
                regwrite_q <= RegWriteE;
                memwrite_q <= MemWriteE;
                rsrc_q     <= ResultSrcE;
            end
        end
    end

    assign load   = (rsrc_q == 2'b01);
    assign mem_op = load | memwrite_q;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    // Half needs a[0]=0, word needs a[1:0]=00; bytes are always aligned
    always_comb begin
        misalign = 1'b0;
        case (funct3_q[1:0])
            2'b01:   misalign = alu_q[0];
            2'b10:   misalign = |alu_q[1:0];
            default: misalign = 1'b0;
        endcase
        misalign = misalign & mem_op;
    end
`else
    assign misalign = 1'b0;
`endif

    // Register contents are frozen while BUSY, so the request stays asserted and stable
    assign req    = (state_q == StBusy) | (mem_op & ~misalign);
    assign StallM = req & ~dmem.DMemReady;

    // Access FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Access FSM next state: wait in BUSY until memory reports ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req && !dmem.DMemReady) state_d = StBusy;
            StBusy:  if (dmem.DMemReady) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Store lane steering: replicate the datum across the word, enable its lanes
    always_comb begin
        dmem.DMemBe    = 4'b0000;
        dmem.DMemWData = wdata_q;
        if (memwrite_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    dmem.DMemBe    = 4'b0001 << alu_q[1:0];
                    dmem.DMemWData = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    dmem.DMemBe    = 4'b0011 << {alu_q[1], 1'b0};
                    dmem.DMemWData = {2{wdata_q[15:0]}};
                end
                default: dmem.DMemBe = 4'b1111;
            endcase
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        ReadDataM = '0;
        case (alu_q[1:0])
            2'b00:   rbyte = dmem.DMemRData[7:0];
            2'b01:   rbyte = dmem.DMemRData[15:8];
            2'b10:   rbyte = dmem.DMemRData[23:16];
            default: rbyte = dmem.DMemRData[31:24];
        endcase
        rhalf = alu_q[1] ? dmem.DMemRData[31:16] : dmem.DMemRData[15:0];
        if (load) begin
            case (funct3_q)
                3'b000:  ReadDataM = {{24{rbyte[7]}}, rbyte};
                3'b001:  ReadDataM = {{16{rhalf[15]}}, rhalf};
                3'b100:  ReadDataM = {24'b0, rbyte};
                3'b101:  ReadDataM = {16'b0, rhalf};
                default: ReadDataM = dmem.DMemRData;
            endcase
        end
    end

    assign dmem.DMemReq  = req;
    assign dmem.DMemWe   = memwrite_q;
    assign dmem.DMemAddr = {alu_q[XLEN-1:2], 2'b00};

    assign ALUResultM = alu_q;
    assign WriteDataM = wdata_q;
    assign PCPlus4M   = pc4_q;
    assign RdM        = rd_q;
    assign ResultSrcM = rsrc_q;
    assign RegWriteM  = regwrite_q & ~(misalign & load);
    assign MisalignM  = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and pushes the
// expected MEM-stage view, a responder models a wait-state data memory, and a
// monitor pops and compares each instruction as it leaves the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, FlushE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ReadDataM;
    logic [4:0]  RdM;
    logic        RegWriteM, StallM, MisalignM;
    logic [1:0]  ResultSrcM;

    mem_stage_if #(.XLEN(32)) ifc ();

    mem_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .Funct3E    (Funct3E),
        .PCPlus4E   (PCPlus4E),
        .FlushE     (FlushE),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .dmem       (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       kind;    // 0 alu, 1 load, 2 store, 3 link
        bit       flush;
        bit       regwrite;
        bit [4:0] rd;
        bit [2:0] f3;
        bit [31:0] a, d, pc4;
        int       waits;
    } instr_t;

    typedef struct {
        bit        bubble, regwrite, req, we, mis;
        bit [4:0]  rd;
        bit [1:0]  rsrc;
        bit [31:0] alu, pc4, addr, wdata, rdata;
        bit [3:0]  be;
        int        waits;
    } exp_t;

    int        n_tests = 0;
    int        n_fail  = 0;
    exp_t      sb_q[$];
    int        wait_q[$];
    bit        mon_en = 1'b0;
    int        stall_cnt = 0;
    int        pending = -1;
    bit [7:0]  model_mem [64];
    logic [31:0] resp_mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: per-request wait count taken from wait_q
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = -1;
            wait_q.delete();
            ifc.DMemReady = 1'b0;
            ifc.DMemRData = 32'h0;
        end else if (ifc.DMemReq) begin
            if (pending < 0) begin
                if (wait_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got req at %08h, required none", ifc.DMemAddr);
                    pending = 0;
                end else begin
                    pending = wait_q.pop_front();
                end
            end
            if (pending > 0) begin
                ifc.DMemReady = 1'b0;
                ifc.DMemRData = $urandom;
                pending--;
            end else begin
                ifc.DMemReady = 1'b1;
                ifc.DMemRData = resp_mem[ifc.DMemAddr[5:2]];
                if (ifc.DMemWe)
                    for (int k = 0; k < 4; k++)
                        if (ifc.DMemBe[k])
                            resp_mem[ifc.DMemAddr[5:2]][8*k +: 8] = ifc.DMemWData[8*k +: 8];
                pending = -1;
            end
        end else begin
            ifc.DMemReady = 1'($urandom_range(0, 1));
            ifc.DMemRData = $urandom;
        end
    end

    // Monitor: check the stalled instruction for stability, pop when it leaves
    always @(negedge clk) begin : monitor
        exp_t e;
        #3;
        if (mon_en && sb_q.size() > 0) begin
            if (StallM) begin
                stall_cnt++;
                chk("busy_req", ifc.DMemReq, 1);
                chk("busy_addr", ifc.DMemAddr, sb_q[0].addr);
                chk("busy_be", ifc.DMemBe, sb_q[0].be);
            end else begin
                e = sb_q.pop_front();
                chk("stall_cycles", stall_cnt, e.waits);
                stall_cnt = 0;
                chk("regwrite", RegWriteM, e.regwrite);
                chk("resultsrc", ResultSrcM, e.rsrc);
                chk("req", ifc.DMemReq, e.req);
                chk("misalign", MisalignM, e.mis);
                if (!e.bubble) begin
                    chk("rd", RdM, e.rd);
                    chk("alu", ALUResultM, e.alu);
                    chk("pc4", PCPlus4M, e.pc4);
                end
                if (e.req) begin
                    chk("we", ifc.DMemWe, e.we);
                    chk("addr", ifc.DMemAddr, e.addr);
                    chk("be", ifc.DMemBe, e.be);
                    if (e.we) chk("wdata", ifc.DMemWData, e.wdata);
                end
                if (!e.mis) chk("rdata", ReadDataM, e.rdata);
            end
        end
    end

    task automatic junk();
        ALUResultE = $urandom;
        WriteDataE = $urandom;
        PCPlus4E   = $urandom;
        RdE        = 5'($urandom);
        RegWriteE  = 1'($urandom);
        MemWriteE  = 1'($urandom);
        ResultSrcE = 2'($urandom);
        Funct3E    = 3'($urandom);
        FlushE     = 1'($urandom);
    endtask

    task automatic drive_bubble();
        ALUResultE = 0; WriteDataE = 0; PCPlus4E = 0; RdE = 0;
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; Funct3E = 0; FlushE = 1;
    endtask

    // Wait for a free slot, present the instruction, predict its MEM view
    task automatic issue(input instr_t in);
        exp_t      e;
        int        guard = 0;
        int        n, off, base;
        bit        is_load, is_store;
        bit [1:0]  rsrc;
        bit [31:0] raw;
        while (1) begin
            @(negedge clk);
            #1;
            if (!StallM) break;
            junk();
            guard++;
            if (guard > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_timeout: stall=%0d after %0d cycles, required 0", StallM, guard);
                break;
            end
        end
        is_load  = (in.kind == 1);
        is_store = (in.kind == 2);
        rsrc     = is_load ? 2'b01 : (in.kind == 3) ? 2'b10 : 2'b00;
        ALUResultE = in.a;  WriteDataE = in.d;  PCPlus4E = in.pc4;  RdE = in.rd;
        RegWriteE  = in.regwrite;  MemWriteE = is_store;  ResultSrcE = rsrc;
        Funct3E    = in.f3;  FlushE = in.flush;

        e = '{default: 0};
        e.bubble = in.flush;
        e.rd     = in.rd;
        e.alu    = in.a;
        e.pc4    = in.pc4;
        if (!in.flush) begin
            e.rsrc     = rsrc;
            e.regwrite = in.regwrite;
            e.we       = is_store;
            n   = (in.f3[1:0] == 2'b00) ? 1 : (in.f3[1:0] == 2'b01) ? 2 : 4;
            off = (int'(in.a[1:0]) / n) * n;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            e.mis = (is_load || is_store) && (int'(in.a[1:0]) % n != 0);
`endif
            e.req  = (is_load || is_store) && !e.mis;
            e.addr = in.a & ~32'h3;
            base   = int'(e.addr) - 32'h100;
            if (is_store) begin
                e.be = 4'(((1 << n) - 1) << off);
                for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = in.d[8*(k % n) +: 8];
                if (!e.mis)
                    for (int j = 0; j < n; j++) model_mem[base + off + j] = in.d[8*j +: 8];
            end
            if (is_load) begin
                raw = 0;
                for (int j = 0; j < n; j++) raw[8*j +: 8] = model_mem[base + off + j];
                if (!in.f3[2] && n < 4 && raw[8*n - 1]) raw = raw | (32'hFFFF_FFFF << (8*n));
                e.rdata = raw;
                if (e.mis) e.regwrite = 0;
            end
            if (e.req) begin
                e.waits = in.waits;
                wait_q.push_back(in.waits);
            end
        end
        sb_q.push_back(e);
    endtask

    function automatic instr_t mk(int kind, bit [2:0] f3, bit [31:0] a, bit [31:0] d, int waits);
        instr_t r;
        r.kind = kind;  r.flush = 0;  r.regwrite = (kind != 2);  r.rd = 5'd7;
        r.f3 = f3;  r.a = a;  r.d = d;  r.pc4 = a + 4;  r.waits = waits;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.kind  = $urandom_range(0, 3);
        r.flush = ($urandom_range(0, 9) == 0);
        r.rd    = 5'($urandom);
        r.pc4   = $urandom;
        r.d     = $urandom;
        r.waits = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
        r.a     = $urandom;
        r.f3    = 3'($urandom);
        r.regwrite = 1'($urandom);
        case (r.kind)
            1: begin
                r.a = 32'h100 + $urandom_range(0, 63);
                case ($urandom_range(0, 4))
                    0: r.f3 = 3'b000;
                    1: r.f3 = 3'b001;
                    2: r.f3 = 3'b010;
                    3: r.f3 = 3'b100;
                    default: r.f3 = 3'b101;
                endcase
                r.regwrite = 1;
            end
            2: begin
                r.a  = 32'h100 + $urandom_range(0, 63);
                r.f3 = 3'($urandom_range(0, 2));
                r.regwrite = 0;
            end
            3: r.regwrite = 1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic drain();
        instr_t b;
        int     g = 0;
        b = mk(0, 0, 0, 0, 0);
        b.flush = 1;
        issue(b);
        while (sb_q.size() != 0 && g < 60) begin
            @(negedge clk);
            #4;
            g++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
        end
    endtask

    task automatic release_reset();
        exp_t b;
        b = '{default: 0};
        b.bubble = 1;
        @(negedge clk);
        #4;
        rst_n = 1'b1;
        stall_cnt = 0;
        sb_q.push_back(b);
        mon_en = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b0;
        drive_bubble();
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            resp_mem[i] = w;
            for (int j = 0; j < 4; j++) model_mem[4*i + j] = w[8*j +: 8];
        end
        #12;
        chk("rst_req", ifc.DMemReq, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_regwrite", RegWriteM, 0);
        chk("rst_alu", ALUResultM, 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_misalign", MisalignM, 0);
        release_reset();

        // Directed: sw, sb lane 3, lb/lbu sign vs zero, 3-wait lw, half at odd address
        issue(mk(2, 3'b010, 32'h100, 32'hDEADBEEF, 0));
        issue(mk(2, 3'b000, 32'h103, 32'h000000A5, 0));
        issue(mk(2, 3'b010, 32'h100, 32'h00800000, 1));
        issue(mk(1, 3'b000, 32'h102, 32'h0, 0));
        issue(mk(1, 3'b100, 32'h102, 32'h0, 2));
        issue(mk(1, 3'b010, 32'h100, 32'h0, 3));
        issue(mk(1, 3'b001, 32'h101, 32'h0, 0));
        issue(mk(2, 3'b001, 32'h10E, 32'h0000C3D2, 0));
        issue(mk(1, 3'b101, 32'h10E, 32'h0, 1));
        issue(mk(1, 3'b001, 32'h10E, 32'h0, 0));

        repeat (300) issue(rand_instr());
        drain();

        // Reset while an access is outstanding
        mon_en = 1'b0;
        issue(mk(1, 3'b010, 32'h108, 32'h0, 5));
        @(negedge clk);
        #1;
        chk("pre_rst_stall", StallM, 1);
        @(negedge clk);
        #1;
        chk("pre_rst_req", ifc.DMemReq, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", ifc.DMemReq, 0);
        chk("midrst_stall", StallM, 0);
        chk("midrst_regwrite", RegWriteM, 0);
        chk("midrst_resultsrc", ResultSrcM, 0);
        sb_q.delete();
        drive_bubble();
        release_reset();

        // Fresh accesses after reset must not inherit the abandoned one
        issue(mk(2, 3'b010, 32'h104, 32'h12345678, 0));
        issue(mk(1, 3'b010, 32'h104, 32'h0, 0));
        issue(mk(1, 3'b000, 32'h107, 32'h0, 2));
        issue(mk(3, 3'b000, 32'h0, 32'h0, 0));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
